// File: rtl/adj_button_conditioner.sv
// Time-adjust button front end: per-button 2-flop sync, tick-based debounce,
// and a single-cycle adjust pulse on each accepted press, with hold-to-auto-repeat.
module adj_button_conditioner #(
    parameter int unsigned TICK_DIV            = 31500,
    parameter int unsigned DEBOUNCE_TICKS      = 20,
    parameter int unsigned REPEAT_DELAY_TICKS  = 500,
    parameter int unsigned REPEAT_PERIOD_TICKS = 100,
    parameter bit          ACTIVE_LOW          = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] btn_raw,
    output logic       adj_hrs,
    output logic       adj_min,
    output logic       adj_sec,
    output logic [2:0] btn_level
);

    localparam int unsigned MAX_A = (DEBOUNCE_TICKS > REPEAT_DELAY_TICKS) ?
                                    DEBOUNCE_TICKS : REPEAT_DELAY_TICKS;
    localparam int unsigned MAX_T = (MAX_A > REPEAT_PERIOD_TICKS) ? MAX_A : REPEAT_PERIOD_TICKS;
    localparam int unsigned CW    = $clog2(MAX_T + 1);
    localparam int unsigned TW    = $clog2(TICK_DIV);

    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_TICKS - 1);
    localparam logic [CW-1:0] RD_LAST  = CW'(REPEAT_DELAY_TICKS - 1);
    localparam logic [CW-1:0] RP_LAST  = CW'(REPEAT_PERIOD_TICKS - 1);
    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESS_WAIT,
        ST_HELD_DELAY,
        ST_HELD_REPEAT,
        ST_RELEASE_WAIT
    } state_t;

    logic [2:0]    w_btn;
    logic [2:0]    r_sync1;
    logic [2:0]    r_sync2;
    logic [TW-1:0] r_presc;
    logic          w_tick;
    logic [2:0]    w_pulse;
    logic [2:0]    w_level;

    assign w_btn  = ACTIVE_LOW ? ~btn_raw : btn_raw;
    assign w_tick = (r_presc == TICK_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_btn;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_ch
        state_t        r_state;
        state_t        w_state_nx;
        logic [CW-1:0] r_cnt;
        logic [CW-1:0] w_cnt_nx;
        logic          w_fire;
        logic          w_s;
        logic          r_pulse;
        logic          r_level;

        assign w_s = r_sync2[g];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_pulse <= 1'b0;
                r_level <= 1'b0;
            end else begin
                r_state <= w_state_nx;
                r_cnt   <= w_cnt_nx;
                r_pulse <= w_fire;
                r_level <= (w_state_nx inside {ST_HELD_DELAY, ST_HELD_REPEAT, ST_RELEASE_WAIT});
            end
        end

        // A level change always takes priority over a tick landing in the same cycle.
        always_comb begin
            w_state_nx = r_state;
            w_cnt_nx   = r_cnt;
            w_fire     = 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_s) begin
                        w_state_nx = ST_PRESS_WAIT;
                        w_cnt_nx   = '0;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!w_s) begin
                        w_state_nx = ST_IDLE;
                        w_cnt_nx   = '0;
                    end else if (w_tick) begin
                        if (r_cnt == DEB_LAST) begin
                            w_state_nx = ST_HELD_DELAY;
                            w_cnt_nx   = '0;
                            w_fire     = 1'b1;
                        end else begin
                            w_cnt_nx = r_cnt + 1'b1;
                        end
                    end
                end
                ST_HELD_DELAY: begin
                    if (!w_s) begin
                        w_state_nx = ST_RELEASE_WAIT;
                        w_cnt_nx   = '0;
                    end else if (w_tick) begin
                        if (r_cnt == RD_LAST) begin
                            w_state_nx = ST_HELD_REPEAT;
                            w_cnt_nx   = '0;
                            w_fire     = 1'b1;
                        end else begin
                            w_cnt_nx = r_cnt + 1'b1;
                        end
                    end
                end
                ST_HELD_REPEAT: begin
                    if (!w_s) begin
                        w_state_nx = ST_RELEASE_WAIT;
                        w_cnt_nx   = '0;
                    end else if (w_tick) begin
                        if (r_cnt == RP_LAST) begin
                            w_cnt_nx = '0;
                            w_fire   = 1'b1;
                        end else begin
                            w_cnt_nx = r_cnt + 1'b1;
                        end
                    end
                end
                ST_RELEASE_WAIT: begin
                    // Re-press during release bounce resumes the hold without a new pulse.
                    if (w_s) begin
                        w_state_nx = ST_HELD_DELAY;
                        w_cnt_nx   = '0;
                    end else if (w_tick) begin
                        if (r_cnt == DEB_LAST) begin
                            w_state_nx = ST_IDLE;
                            w_cnt_nx   = '0;
                        end else begin
                            w_cnt_nx = r_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nx = ST_IDLE;
                    w_cnt_nx   = '0;
                end
            endcase
        end

        assign w_pulse[g] = r_pulse;
        assign w_level[g] = r_level;
    end

    assign adj_hrs   = w_pulse[0];
    assign adj_min   = w_pulse[1];
    assign adj_sec   = w_pulse[2];
    assign btn_level = w_level;

endmodule
